mem_stage_lsu: RTL and testbench
================================

MEM_STAGE_LSU -- requirements
Module: mem_stage_lsu

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 16, giving the maximum ACCESS cycles to wait for mem_ack_i before abort.
REQ-002 The block SHALL have these ports: clk, input, 1, the single clock, rising edge.
REQ-003 reset  input  1  reset; asynchronous, active-low.
REQ-004 mem_to_reg_i, mem_read_i, mem_write_i, reg_write_i  input  1 each  controls from the EX/MEM register.
REQ-005 write_register_i  input  5  destination register; alu_result_i  input  32  address/ALU result; read_data_2_i  input  32  store data.
REQ-006 mem_req_o  output  1  memory request; mem_we_o  output  1  write enable; mem_addr_o  output  32; mem_wdata_o  output  32.
REQ-007 mem_ack_i  input  1  one-cycle completion pulse; mem_rdata_i  input  32  load data, valid with mem_ack_i.
REQ-008 stall_o  output  1  freezes PC, IF/ID, ID/EX and EX/MEM when high.
REQ-009 mem_to_reg_o, reg_write_o  output  1 each; write_register_o  output  5; alu_result_o, read_data_o  output  32: MEM/WB register outputs.
REQ-010 misalign_o, bus_error_o  output  1 each  one-cycle registered exception pulses.

Function
REQ-011 The FSM SHALL have states IDLE, ACCESS, DONE.
REQ-012 "Mem op" SHALL mean mem_read_i or mem_write_i high; "aligned" SHALL mean alu_result_i[1:0] == 0.
REQ-013 In IDLE with no mem op: stall_o=0; at the clock edge MEM/WB SHALL load all five *_i fields directly (read_data_o <= 0); the FSM SHALL remain in IDLE.
REQ-014 In IDLE with an aligned mem op: stall_o=1 combinationally; at the edge the block SHALL latch mem_addr_o <= alu_result_i, mem_wdata_o <= read_data_2_i, mem_we_o <= mem_write_i, set mem_req_o <= 1, clear the timeout counter and go to ACCESS.
REQ-015 While stall_o=1 the MEM/WB register SHALL load a bubble (reg_write_o=0, mem_to_reg_o=0; other fields hold).
REQ-016 In ACCESS: stall_o=1; mem_req_o, mem_addr_o, mem_wdata_o and mem_we_o SHALL stay stable until the ack or timeout edge.
REQ-017 In ACCESS with mem_ack_i=1: at the edge the block SHALL capture mem_rdata_i (loads only; stores capture 0), drop mem_req_o and go to DONE.
REQ-018 In ACCESS with no ack: the counter SHALL increment; when it reaches TIMEOUT_CYCLES-1 without ack, the block SHALL drop mem_req_o, flag an error and go to DONE; an ack in that same cycle SHALL win (no error).
REQ-019 In DONE: stall_o=0; at the edge MEM/WB SHALL load the held EX/MEM fields with read_data_o = captured data, except that reg_write_o SHALL be forced 0 and bus_error_o pulsed for 1 cycle if the error flag is set; next state IDLE.
REQ-020 mem_ack_i outside ACCESS SHALL be ignored.
REQ-021 In IDLE with a misaligned mem op: no request and stall_o=0; at the edge MEM/WB SHALL load the fields with reg_write_o forced 0, and misalign_o SHALL pulse for 1 cycle.
REQ-022 Latency: a non-memory op SHALL reach MEM/WB 1 edge after entry; an aligned op with ack in the first ACCESS cycle SHALL reach it on the 3rd edge, giving 2 stall cycles; each extra wait cycle SHALL add 1.
REQ-023 The counter width SHALL be $clog2(TIMEOUT_CYCLES); it SHALL never wrap within one access.

Reset
REQ-024 While reset=0, asynchronously: state SHALL be IDLE; every output, register and counter SHALL be 0; mem_req_o SHALL be 0 immediately, including mid-ACCESS.
REQ-025 After reset release, an in-flight access SHALL NOT be resumed, and late acks SHALL be ignored per REQ-020.

Verification
REQ-026 ALU op, alu_result_i=0x10, reg_write_i=1, write_register_i=5 -> next edge alu_result_o=0x10, reg_write_o=1, write_register_o=5, stall_o=0 throughout.
REQ-027 Load at 0x100, ack with rdata=0xDEADBEEF on first ACCESS cycle -> stall_o high for 2 cycles, read_data_o=0xDEADBEEF, mem_to_reg_o=1 at 3rd edge; reg_write_o=0 before that.
REQ-028 Store to 0x204 with data 0x1234, ack after 4 wait cycles -> mem_we_o=1, mem_addr_o=0x204, mem_wdata_o=0x1234 stable for the whole request; stall_o high for 6 cycles.
REQ-029 Load at 0x102 -> no mem_req_o, misalign_o pulses once, reg_write_o=0, stall_o=0.
REQ-030 Load, no ack, TIMEOUT_CYCLES=16 -> mem_req_o drops after 16 ACCESS cycles, bus_error_o pulses once, reg_write_o=0; ack exactly on the 16th cycle -> data written back with no error.
REQ-031 reset asserted mid-ACCESS -> mem_req_o=0 and stall_o=0 immediately, state IDLE; an ack after release causes no MEM/WB update.

Source files
------------

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: MEM pipeline stage load/store unit with a MEM/WB register.
// A memory op holds the pipeline frozen while a single request is
// outstanding on a req/ack bus. The request is abandoned after
// TIMEOUT_CYCLES ACCESS cycles without an ack.
//
// Ports
//   clk, rst_n             clock (rising edge), async active-low reset
//   *_i (EX/MEM)           mem_to_reg, mem_read, mem_write, reg_write,
//                          write_register[4:0], alu_result[31:0], read_data_2[31:0]
//   mem_req_o/we/addr/wdata  memory request, stable for the whole access
//   mem_ack_i, mem_rdata_i   one-cycle completion pulse and its load data
//   stall_o                freezes PC, IF/ID, ID/EX and EX/MEM
//   MEM/WB outputs         mem_to_reg_o, reg_write_o, write_register_o,
//                          alu_result_o, read_data_o
//   misalign_o, bus_error_o  one-cycle exception pulses
//
// state  | meaning
// IDLE   | pass-through; an aligned mem op launches a request
// ACCESS | request outstanding, waiting for ack or timeout
// DONE   | write the finished access into MEM/WB
module mem_stage_lsu #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_to_reg_i,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic        reg_write_i,
  input  logic [4:0]  write_register_i,
  input  logic [31:0] alu_result_i,
  input  logic [31:0] read_data_2_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic        stall_o,
  output logic        mem_to_reg_o,
  output logic        reg_write_o,
  output logic [4:0]  write_register_o,
  output logic [31:0] alu_result_o,
  output logic [31:0] read_data_o,
  output logic        misalign_o,
  output logic        bus_error_o
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic          err;
  logic [31:0]   cap_data;
  logic          h_mem_to_reg, h_reg_write;
  logic [4:0]    h_write_register;
  logic [31:0]   h_alu_result;
  logic          mem_op, aligned, timeout, stall;

  assign mem_op  = mem_read_i | mem_write_i;
  assign aligned = (alu_result_i[1:0] == 2'b00);
  assign timeout = (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    case (state)
      IDLE: begin
        if (mem_op && aligned) begin
          stall     = 1'b1;
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        stall = 1'b1;
        if (mem_ack_i || timeout) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Gated so the freeze releases the instant reset is asserted, even if
  // the EX/MEM inputs still present a mem op.
  assign stall_o = rst_n & stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_req_o        <= 1'b0;
      mem_we_o         <= 1'b0;
      mem_addr_o       <= '0;
      mem_wdata_o      <= '0;
      mem_to_reg_o     <= 1'b0;
      reg_write_o      <= 1'b0;
      write_register_o <= '0;
      alu_result_o     <= '0;
      read_data_o      <= '0;
      misalign_o       <= 1'b0;
      bus_error_o      <= 1'b0;
      cnt              <= '0;
      err              <= 1'b0;
      cap_data         <= '0;
      h_mem_to_reg     <= 1'b0;
      h_reg_write      <= 1'b0;
      h_write_register <= '0;
      h_alu_result     <= '0;
    end else begin
      misalign_o  <= 1'b0;
      bus_error_o <= 1'b0;
      case (state)
        IDLE: begin
          if (mem_op && aligned) begin
            mem_addr_o       <= alu_result_i;
            mem_wdata_o      <= read_data_2_i;
            mem_we_o         <= mem_write_i;
            mem_req_o        <= 1'b1;
            cnt              <= '0;
            err              <= 1'b0;
            h_mem_to_reg     <= mem_to_reg_i;
            h_reg_write      <= reg_write_i;
            h_write_register <= write_register_i;
            h_alu_result     <= alu_result_i;
            reg_write_o      <= 1'b0;
            mem_to_reg_o     <= 1'b0;
          end else begin
            // Plain op or misaligned op: pass straight through; a misaligned
            // op never touches the bus and must not write back.
            mem_to_reg_o     <= mem_to_reg_i;
            reg_write_o      <= reg_write_i & ~mem_op;
            write_register_o <= write_register_i;
            alu_result_o     <= alu_result_i;
            read_data_o      <= '0;
            misalign_o       <= mem_op;
          end
        end
        ACCESS: begin
          reg_write_o  <= 1'b0;
          mem_to_reg_o <= 1'b0;
          if (mem_ack_i) begin
            cap_data  <= mem_we_o ? 32'd0 : mem_rdata_i;
            mem_req_o <= 1'b0;
          end else if (timeout) begin
            cap_data  <= '0;
            mem_req_o <= 1'b0;
            err       <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          mem_to_reg_o     <= h_mem_to_reg;
          reg_write_o      <= h_reg_write & ~err;
          write_register_o <= h_write_register;
          alu_result_o     <= h_alu_result;
          read_data_o      <= cap_data;
          bus_error_o      <= err;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_to_reg_i, mem_read_i, mem_write_i, reg_write_i;
  logic [4:0]  write_register_i;
  logic [31:0] alu_result_i, read_data_2_i;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;
  logic        stall_o;
  logic        mem_to_reg_o, reg_write_o;
  logic [4:0]  write_register_o;
  logic [31:0] alu_result_o, read_data_o;
  logic        misalign_o, bus_error_o;

  int n_chk  = 0;
  int n_pass = 0;
  int stall_cnt = 0;
  int req_cnt;

  mem_stage_lsu #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_to_reg_i(mem_to_reg_i), .mem_read_i(mem_read_i),
    .mem_write_i(mem_write_i), .reg_write_i(reg_write_i),
    .write_register_i(write_register_i), .alu_result_i(alu_result_i),
    .read_data_2_i(read_data_2_i),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
    .stall_o(stall_o),
    .mem_to_reg_o(mem_to_reg_o), .reg_write_o(reg_write_o),
    .write_register_o(write_register_o), .alu_result_o(alu_result_o),
    .read_data_o(read_data_o),
    .misalign_o(misalign_o), .bus_error_o(bus_error_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (stall_o) stall_cnt++;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic m2r, input logic mr, input logic mw, input logic rw,
                        input logic [4:0] wr, input logic [31:0] alu, input logic [31:0] d2);
    mem_to_reg_i = m2r; mem_read_i = mr; mem_write_i = mw; reg_write_i = rw;
    write_register_i = wr; alu_result_i = alu; read_data_2_i = d2;
  endtask

  task automatic nop();
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    nop();
    mem_ack_i = 1'b0;
    mem_rdata_i = '0;
    #23;
    chk("rst_stall", stall_o, 0);
    chk("rst_req", mem_req_o, 0);
    chk("rst_rw", reg_write_o, 0);
    chk("rst_alu", alu_result_o, 0);
    rst_n = 1'b1;
    tick();

    // ALU op passes through in one edge
    set_in(1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 32'h10, 32'd0);
    stall_cnt = 0;
    #1 chk("alu_stall_pre", stall_o, 0);
    tick();
    chk("alu_res", alu_result_o, 32'h10);
    chk("alu_rw", reg_write_o, 1);
    chk("alu_wr", write_register_o, 5);
    chk("alu_read_data", read_data_o, 0);
    nop();
    tick();
    chk("alu_stall_cnt", stall_cnt, 0);

    // Load at 0x100, ack on first ACCESS cycle
    set_in(1'b1, 1'b1, 1'b0, 1'b1, 5'd7, 32'h100, 32'd0);
    stall_cnt = 0;
    #1 chk("ld_stall_idle", stall_o, 1);
    tick();
    chk("ld_req", mem_req_o, 1);
    chk("ld_addr", mem_addr_o, 32'h100);
    chk("ld_we", mem_we_o, 0);
    chk("ld_bubble_rw", reg_write_o, 0);
    chk("ld_stall_access", stall_o, 1);
    mem_ack_i = 1'b1; mem_rdata_i = 32'hDEADBEEF;
    tick();
    mem_ack_i = 1'b0; mem_rdata_i = '0;
    chk("ld_req_drop", mem_req_o, 0);
    chk("ld_stall_done", stall_o, 0);
    chk("ld_rw_before", reg_write_o, 0);
    tick();
    nop();
    chk("ld_rdata", read_data_o, 32'hDEADBEEF);
    chk("ld_m2r", mem_to_reg_o, 1);
    chk("ld_rw", reg_write_o, 1);
    chk("ld_wr", write_register_o, 7);
    chk("ld_stall_cnt", stall_cnt, 2);

    // Store to 0x204, ack after 4 wait cycles
    set_in(1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 32'h204, 32'h1234);
    stall_cnt = 0;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("st_req", mem_req_o, 1);
      chk("st_we", mem_we_o, 1);
      chk("st_addr", mem_addr_o, 32'h204);
      chk("st_wdata", mem_wdata_o, 32'h1234);
      if (i == 4) begin mem_ack_i = 1'b1; mem_rdata_i = 32'hFFFF0000; end
      tick();
    end
    mem_ack_i = 1'b0; mem_rdata_i = '0;
    chk("st_req_drop", mem_req_o, 0);
    tick();
    nop();
    chk("st_rdata", read_data_o, 0);
    chk("st_alu", alu_result_o, 32'h204);
    chk("st_stall_cnt", stall_cnt, 6);

    // Misaligned load at 0x102
    set_in(1'b1, 1'b1, 1'b0, 1'b1, 5'd3, 32'h102, 32'd0);
    stall_cnt = 0;
    #1 chk("mis_stall", stall_o, 0);
    tick();
    nop();
    chk("mis_pulse", misalign_o, 1);
    chk("mis_rw", reg_write_o, 0);
    chk("mis_req", mem_req_o, 0);
    chk("mis_alu", alu_result_o, 32'h102);
    tick();
    chk("mis_pulse_end", misalign_o, 0);
    chk("mis_stall_cnt", stall_cnt, 0);

    // Load with no ack: timeout after 16 ACCESS cycles
    set_in(1'b1, 1'b1, 1'b0, 1'b1, 5'd9, 32'h300, 32'd0);
    tick();
    req_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      if (mem_req_o) req_cnt++;
      tick();
    end
    chk("to_req_cycles", req_cnt, 16);
    chk("to_req_drop", mem_req_o, 0);
    chk("to_no_err_yet", bus_error_o, 0);
    tick();
    nop();
    chk("to_bus_err", bus_error_o, 1);
    chk("to_rw", reg_write_o, 0);
    tick();
    chk("to_bus_err_end", bus_error_o, 0);

    // Ack exactly on the 16th ACCESS cycle wins over timeout
    set_in(1'b1, 1'b1, 1'b0, 1'b1, 5'd10, 32'h400, 32'd0);
    tick();
    repeat (15) tick();
    chk("ack16_req", mem_req_o, 1);
    mem_ack_i = 1'b1; mem_rdata_i = 32'hCAFEF00D;
    tick();
    mem_ack_i = 1'b0; mem_rdata_i = '0;
    tick();
    nop();
    chk("ack16_rdata", read_data_o, 32'hCAFEF00D);
    chk("ack16_rw", reg_write_o, 1);
    chk("ack16_err", bus_error_o, 0);
    tick();

    // Reset mid-ACCESS, then a late ack
    set_in(1'b1, 1'b1, 1'b0, 1'b1, 5'd11, 32'h500, 32'd0);
    tick();
    tick();
    chk("rm_req_before", mem_req_o, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rm_req", mem_req_o, 0);
    chk("rm_stall", stall_o, 0);
    nop();
    #3 rst_n = 1'b1;
    tick();
    mem_ack_i = 1'b1; mem_rdata_i = 32'h55;
    tick();
    mem_ack_i = 1'b0; mem_rdata_i = '0;
    tick();
    chk("rm_rdata", read_data_o, 0);
    chk("rm_rw", reg_write_o, 0);
    chk("rm_req_after", mem_req_o, 0);
    chk("rm_stall_after", stall_o, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
